channel_capture: RTL and testbench

Receive-side counterpart of the per-channel DAC driver. It accepts the 256-bit ADC sample stream from the RFSoC IP (16 x 16-bit samples per beat). When armed over GPIO and triggered on a selected channel, it records a programmable number of beats into an internal buffer. It then drains the record to the PS over AXI-Stream, with tlast on the final beat. It sits between the RFSoC ADC AXIS output and the PS DMA, and shares the trigger_in/select_in fabric used by the transmit channels.

---
 rtl/channel_capture_if.sv | 33 +++
 rtl/channel_capture.sv | 279 +++++++++++++++++++++++++++
 tb/tb_channel_capture.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : channel_capture_if                                           |
// | Description : AXI-Stream bundle shared by the ADC input and the PS output  |
// |               of channel_capture.                                          |
// |               master : drives tdata/tvalid/tlast, samples tready           |
// |               slave  : samples tdata/tvalid, drives tready (the ADC side   |
// |                        carries no record framing, so tlast is not part of  |
// |                        the slave view)                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface channel_capture_if #(
   parameter int DATA_W = 256
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface
`default_nettype wire

// File: rtl/channel_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : channel_capture                                              |
// | Description : Per-channel ADC record capture. Armed over GPIO, triggered   |
// |               by the shared trigger_in/select_in fabric, records LEN       |
// |               256-bit beats into an internal RAM, then drains the record   |
// |               to the PS over AXI-Stream with tlast on the final beat.      |
// | Ports       : clk, rst          - clock, async active-high reset           |
// |               gpio_ctrl[15:0]   - [0] arm (rising edge), [1] abort (level),|
// |                                   [15:4] capture length minus one          |
// |               s_axis (slave)    - ADC stream, tready high out of reset     |
// |               m_axis (master)   - captured record towards PS DMA           |
// |               trigger_in        - shared trigger strobe                    |
// |               select_in         - this channel listens to the trigger      |
// |               capture_state     - 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN      |
// |               capture_done      - one-cycle pulse after the tlast beat     |
// | Options     : CHANNEL_CAPTURE_TIMESTAMP_EN - prepend a header beat holding |
// |               the 64-bit cycle count sampled in the trigger cycle.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module channel_capture #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 256
) (
   input  wire logic         clk,
   input  wire logic         rst,
   input  wire logic [15:0]  gpio_ctrl,
   channel_capture_if.slave  s_axis,
   channel_capture_if.master m_axis,
   input  wire logic         trigger_in,
   input  wire logic         select_in,
   output logic [1:0]        capture_state,
   output logic              capture_done
);

   localparam int               c_aw    = $clog2(DEPTH);
   localparam int               c_cw    = c_aw + 1;
   localparam logic [12:0]      c_depth = 13'(DEPTH);
   localparam logic [c_cw-1:0]  c_one   = c_cw'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic                r_arm_d;
   logic                r_s_rdy;
   logic [c_cw-1:0]     r_len;
   logic [c_cw-1:0]     r_wr_cnt;
   logic [c_cw-1:0]     r_rd_cnt;

   // Read pipeline: RAM output stage (q) followed by the AXIS output stage (m)
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_q_vld;
   logic                r_q_last;
   logic [DATA_W-1:0]   r_m_data;
   logic                r_m_vld;
   logic                r_m_last;
   logic                r_done;

   logic                w_arm_edge;
   logic                w_abort;
   logic                w_trig;
   logic [12:0]         w_len_req;
   logic [12:0]         w_len_sel;
   logic                w_wr_en;
   logic                w_wr_last;
   logic                w_in_drain;
   logic                w_out_adv;
   logic                w_q_adv;
   logic                w_more;
   logic                w_rd_en;
   logic                w_hdr_issue;
   logic                w_done_set;
   logic [DATA_W-1:0]   w_q_data;
   logic                w_unused;

   // gpio_ctrl[3:2] are reserved
   assign w_unused   = &{1'b0, gpio_ctrl[3:2]};

   assign w_abort    = gpio_ctrl[1];
   assign w_arm_edge = gpio_ctrl[0] & ~r_arm_d;
   assign w_trig     = trigger_in & select_in;

   // Field 0 means one beat; anything past the buffer is clamped to DEPTH
   assign w_len_req  = {1'b0, gpio_ctrl[15:4]} + 13'd1;
   assign w_len_sel  = (w_len_req > c_depth) ? c_depth : w_len_req;

   assign w_wr_en    = (r_state == S_CAPTURE) && s_axis.tvalid && !w_abort;
   assign w_wr_last  = w_wr_en && ((r_wr_cnt + c_one) == r_len);

   // Drain pipeline control. The output stage advances when empty or when the
   // PS takes the current beat; the RAM stage refills whenever it drains.
   assign w_in_drain = (r_state == S_DRAIN) && !w_abort;
   assign w_out_adv  = !r_m_vld || m_axis.tready;
   assign w_q_adv    = !r_q_vld || w_out_adv;
   assign w_more     = (r_rd_cnt != r_len);

`ifdef CHANNEL_CAPTURE_TIMESTAMP_EN
   logic [63:0]         r_ts_cnt;
   logic [63:0]         r_ts;
   logic                r_hdr_pend;
   logic                r_q_hdr;

   // Header beat goes out ahead of every data read
   assign w_hdr_issue = w_in_drain && r_hdr_pend && w_q_adv;
   assign w_rd_en     = w_in_drain && !r_hdr_pend && w_more && w_q_adv;
   assign w_q_data    = r_q_hdr ? {{(DATA_W-64){1'b0}}, r_ts} : r_rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ts_cnt   <= 64'd0;
         r_ts       <= 64'd0;
         r_hdr_pend <= 1'b0;
         r_q_hdr    <= 1'b0;
      end else begin
         r_ts_cnt <= r_ts_cnt + 64'd1;
         if (w_abort) begin
            r_hdr_pend <= 1'b0;
         end else if ((r_state == S_ARMED) && w_trig) begin
            r_ts       <= r_ts_cnt;
            r_hdr_pend <= 1'b1;
         end else if (w_hdr_issue) begin
            r_hdr_pend <= 1'b0;
         end
         if (w_hdr_issue) begin
            r_q_hdr <= 1'b1;
         end else if (w_rd_en) begin
            r_q_hdr <= 1'b0;
         end
      end
   end
`else
   assign w_hdr_issue = 1'b0;
   assign w_rd_en     = w_in_drain && w_more && w_q_adv;
   assign w_q_data    = r_rd_data;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_done_set = 1'b0;
      if (w_abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_arm_edge) begin
                  w_next = S_ARMED;
               end
            end
            S_ARMED: begin
               if (w_trig) begin
                  w_next = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (w_wr_last) begin
                  w_next = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (r_m_vld && m_axis.tready && r_m_last) begin
                  w_next     = S_IDLE;
                  w_done_set = 1'b1;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------- control regs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arm_d  <= 1'b0;
         r_s_rdy  <= 1'b0;
         r_len    <= c_one;
         r_wr_cnt <= '0;
         r_rd_cnt <= '0;
         r_done   <= 1'b0;
      end else begin
         r_arm_d <= gpio_ctrl[0];
         r_s_rdy <= 1'b1;
         r_done  <= w_done_set;

         if ((r_state == S_IDLE) && w_arm_edge && !w_abort) begin
            r_len <= c_cw'(w_len_sel);
         end

         if (w_abort || (r_state != S_CAPTURE)) begin
            r_wr_cnt <= '0;
         end else if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + c_one;
         end

         if (w_abort || (r_state != S_DRAIN)) begin
            r_rd_cnt <= '0;
         end else if (w_rd_en) begin
            r_rd_cnt <= r_rd_cnt + c_one;
         end
      end
   end

   // ------------------------------------------------ capture buffer (BRAM)
   // Capture and drain are mutually exclusive, so one write port and one
   // registered read port are enough and no collision handling is needed.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_cnt[c_aw-1:0]] <= s_axis.tdata;
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[r_rd_cnt[c_aw-1:0]];
      end
   end

   // -------------------------------------------------- RAM output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_vld  <= 1'b0;
         r_q_last <= 1'b0;
      end else if (!w_in_drain) begin
         r_q_vld  <= 1'b0;
         r_q_last <= 1'b0;
      end else if (w_hdr_issue) begin
         r_q_vld  <= 1'b1;
         r_q_last <= 1'b0;
      end else if (w_rd_en) begin
         r_q_vld  <= 1'b1;
         r_q_last <= ((r_rd_cnt + c_one) == r_len);
      end else if (w_out_adv) begin
         r_q_vld  <= 1'b0;
      end
   end

   // ------------------------------------------------- AXIS output stage
   // Held while tvalid && !tready; an abort drops the beat in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_vld  <= 1'b0;
         r_m_last <= 1'b0;
         r_m_data <= '0;
      end else if (!w_in_drain) begin
         r_m_vld  <= 1'b0;
         r_m_last <= 1'b0;
      end else if (w_out_adv) begin
         r_m_vld <= r_q_vld;
         if (r_q_vld) begin
            r_m_data <= w_q_data;
            r_m_last <= r_q_last;
         end else begin
            r_m_last <= 1'b0;
         end
      end
   end

   assign s_axis.tready = r_s_rdy;
   assign m_axis.tdata  = r_m_data;
   assign m_axis.tvalid = r_m_vld;
   assign m_axis.tlast  = r_m_last;
   assign capture_state = r_state;
   assign capture_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_channel_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_channel_capture                                           |
// | Description : Self-checking bench for channel_capture. Expected output     |
// |               beats are queued while ADC stimulus is driven and compared   |
// |               as the PS side takes them.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_channel_capture;
   localparam int DEPTH  = 1024;
   localparam int DATA_W = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] gpio_ctrl = 16'h0000;
   logic        trigger_in = 1'b0;
   logic        select_in  = 1'b0;
   logic [1:0]  capture_state;
   logic        capture_done;

   channel_capture_if #(.DATA_W(DATA_W)) s_if ();
   channel_capture_if #(.DATA_W(DATA_W)) m_if ();

   channel_capture #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .gpio_ctrl     (gpio_ctrl),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .trigger_in    (trigger_in),
      .select_in     (select_in),
      .capture_state (capture_state),
      .capture_done  (capture_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

`ifdef CHANNEL_CAPTURE_TIMESTAMP_EN
   localparam int HDR = 1;
   logic [63:0] tb_cyc;
   always @(posedge clk or posedge rst) begin
      if (rst) tb_cyc <= 64'd0;
      else     tb_cyc <= tb_cyc + 64'd1;
   end
`else
   localparam int HDR = 0;
`endif

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      logic [255:0] data;
      logic         last;
   } beat_t;
   beat_t exp_q[$];

   logic         prev_stall = 1'b0;
   logic [255:0] prev_data;
   logic         prev_last;
   logic         done_pend  = 1'b0;
   int           hs_cnt     = 0;
   int           done_cnt   = 0;
   bit           bp_mode    = 1'b0;

   // PS ready: steady high, or toggling every cycle for back-pressure runs
   always @(posedge clk) begin
      #1;
      m_if.tready = bp_mode ? ~m_if.tready : 1'b1;
   end

   // Monitor samples mid-cycle, between the drive point and the next edge
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         done_pend  = 1'b0;
      end else begin
         if (done_pend || capture_done) begin
            check("capture_done pulse", capture_done, done_pend);
            if (done_pend) begin
               check("state after done", capture_state, 0);
               check("tvalid after done", m_if.tvalid, 0);
               if (capture_done) done_cnt++;
            end
            done_pend = 1'b0;
         end
         if (prev_stall) begin
            check("stall tvalid held", m_if.tvalid, 1);
            check("stall tdata held", m_if.tdata, prev_data);
            check("stall tlast held", m_if.tlast, prev_last);
         end
         if (m_if.tvalid && m_if.tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected beat tvalid", m_if.tvalid, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat tdata", m_if.tdata, e.data);
               check("beat tlast", m_if.tlast, e.last);
            end
            hs_cnt++;
            if (m_if.tlast) done_pend = 1'b1;
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev_data  = m_if.tdata;
         prev_last  = m_if.tlast;
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk(input int tag, input int i);
      return {32'(tag), 192'h0, 32'(32'hA0 + i)};
   endfunction

   task automatic do_arm(input logic [11:0] field);
      gpio_ctrl = {field, 4'b0000};
      tick();
      gpio_ctrl[0] = 1'b1;
      tick();
      gpio_ctrl[0] = 1'b0;
   endtask

   // Arm, trigger and feed ADC beats; queue the beats the DUT must return
   task automatic start_capture(input logic [11:0] field, input bit gap, input int n_src,
                                input int exp_len, input int tag);
      int  captured;
      int  i;
      logic v;
      do_arm(field);
      check("armed after arm edge", capture_state, 1);
      trigger_in  = 1'b1;
      select_in   = 1'b1;
      s_if.tvalid = 1'b1;
      s_if.tdata  = mk(tag, 0);       // trigger-cycle beat is discarded
`ifdef CHANNEL_CAPTURE_TIMESTAMP_EN
      exp_q.push_back('{data: {192'b0, tb_cyc}, last: 1'b0});
`endif
      tick();
      trigger_in = 1'b0;
      check("capture after trigger", capture_state, 2);
      captured = 0;
      i = 1;
      while (captured < exp_len || i < n_src) begin
         v = gap ? ((i % 2) == 1) : 1'b1;
         s_if.tvalid = v;
         s_if.tdata  = mk(tag, i);
         if (v && captured < exp_len) begin
            exp_q.push_back('{data: mk(tag, i), last: (captured == exp_len - 1)});
            captured++;
         end
         tick();
         i++;
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic run_capture(input logic [11:0] field, input bit gap, input bit bp,
                              input int n_src, input int exp_len, input int tag);
      int start_hs;
      int start_done;
      int cyc;
      bp_mode    = bp;
      start_hs   = hs_cnt;
      start_done = done_cnt;
      start_capture(field, gap, n_src, exp_len, tag);
      cyc = 0;
      while (done_cnt == start_done && cyc < 5000) begin
         tick();
         cyc++;
      end
      tick();
      check("done pulses in run", done_cnt - start_done, 1);
      check("beats drained", hs_cnt - start_hs, exp_len + HDR);
      check("scoreboard empty", exp_q.size(), 0);
      check("idle after run", capture_state, 0);
      exp_q.delete();
      bp_mode = 1'b0;
   endtask

   typedef struct {
      logic [11:0] field;
      bit          gap;
      bit          bp;
      int          n_src;
      int          exp_len;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #200_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start_hs;
      int start_done;
      int cyc;

      vecs[0] = '{field: 12'd3,  gap: 1'b0, bp: 1'b0, n_src: 8,  exp_len: 4};
      vecs[1] = '{field: 12'd3,  gap: 1'b1, bp: 1'b1, n_src: 12, exp_len: 4};
      vecs[2] = '{field: 12'd0,  gap: 1'b0, bp: 1'b1, n_src: 4,  exp_len: 1};
      vecs[3] = '{field: 12'd15, gap: 1'b1, bp: 1'b0, n_src: 40, exp_len: 16};
      vecs[4] = '{field: 12'd9,  gap: 1'b0, bp: 1'b1, n_src: 14, exp_len: 10};
      vecs[5] = '{field: 12'd1,  gap: 1'b0, bp: 1'b0, n_src: 3,  exp_len: 2};

      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      m_if.tready = 1'b1;

      // ---------------------------------------------------- reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset s_tready", s_if.tready, 0);
      check("reset tvalid", m_if.tvalid, 0);
      check("reset tlast", m_if.tlast, 0);
      check("reset tdata", m_if.tdata, 0);
      check("reset state", capture_state, 0);
      check("reset done", capture_done, 0);
      rst = 1'b0;
      tick();
      check("s_tready after reset", s_if.tready, 1);

      // ------------------------------------------ trigger qualification
      trigger_in = 1'b1;
      select_in  = 1'b1;
      tick();
      trigger_in = 1'b0;
      check("trigger before arm stays idle", capture_state, 0);
      do_arm(12'd3);
      check("armed", capture_state, 1);
      trigger_in = 1'b1;
      select_in  = 1'b0;
      tick();
      trigger_in = 1'b0;
      check("unselected trigger stays armed", capture_state, 1);
      gpio_ctrl[1] = 1'b1;
      tick();
      check("abort from armed", capture_state, 0);
      gpio_ctrl[0] = 1'b1;              // arm edge while abort held
      tick();
      check("arm ignored under abort", capture_state, 0);
      gpio_ctrl[1] = 1'b0;              // arm still high: no new edge
      tick();
      check("no late arm after abort", capture_state, 0);
      gpio_ctrl = 16'h0000;
      tick();

      // -------------------------------------------------- table vectors
      for (int k = 0; k < 6; k++) begin
         run_capture(vecs[k].field, vecs[k].gap, vecs[k].bp, vecs[k].n_src,
                     vecs[k].exp_len, 16 + k);
      end

      // ----------------------------------------------- length clamp
      run_capture(12'hFFF, 1'b0, 1'b0, 1030, DEPTH, 100);

      // -------------------------------------------- abort mid-drain
      start_hs   = hs_cnt;
      start_done = done_cnt;
      start_capture(12'hFFF, 1'b0, 4, DEPTH, 200);
      cyc = 0;
      while ((hs_cnt - start_hs) < 500 && cyc < 3000) begin
         tick();
         cyc++;
      end
      check("drain reached beat 500", (hs_cnt - start_hs) >= 500, 1);
      gpio_ctrl[1] = 1'b1;
      tick();
      check("abort state idle", capture_state, 0);
      check("abort tvalid low", m_if.tvalid, 0);
      check("abort tlast low", m_if.tlast, 0);
      exp_q.delete();
      repeat (4) tick();
      gpio_ctrl[1] = 1'b0;
      repeat (4) tick();
      check("no done after abort", done_cnt - start_done, 0);
      check("idle after abort", capture_state, 0);

      // ---------------------------------------- async reset mid-drain
      bp_mode  = 1'b1;
      start_hs = hs_cnt;
      start_capture(12'd7, 1'b0, 8, 8, 300);
      cyc = 0;
      while ((hs_cnt - start_hs) < 2 && cyc < 100) begin
         tick();
         cyc++;
      end
      check("drain started before reset", (hs_cnt - start_hs) >= 2, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async reset tvalid", m_if.tvalid, 0);
      check("async reset state", capture_state, 0);
      check("async reset s_tready", s_if.tready, 0);
      exp_q.delete();
      bp_mode = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      start_hs = hs_cnt;
      tick();
      check("s_tready after re-release", s_if.tready, 1);
      repeat (10) tick();
      check("no output after reset", hs_cnt - start_hs, 0);
      check("idle after reset", capture_state, 0);

      // --------------------------------------------- post-reset sanity
      run_capture(12'd2, 1'b0, 1'b0, 5, 3, 400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
